// File: rtl/mega8_alu_pkg.sv
// Shared definitions for the serial add path: FSM state encoding and default operand width.
package mega8_alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/serial_adder8_fa_cell.sv
// Single-bit full adder; the only arithmetic cell of the bit-serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder8.sv
// Bit-serial WIDTH-bit adder with carry-in: one bit per clock, LSB first, start/done handshake.
module serial_adder8
  import mega8_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s, fa_c;
  logic             ready, accept, last_bit;
  logic [WIDTH-1:0] acc_next;

  fa_cell u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at acc[0].
  assign acc_next = {fa_s, acc_q[WIDTH-1:1]};
  assign ready    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept   = ready && start;
  assign last_bit = (state_q == S_RUN) && (cnt_q == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST_BIT) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      sa_d    = a;
      sb_d    = b;
      acc_d   = '0;
      cnt_d   = '0;
      carry_d = cin;
      amsb_d  = a[WIDTH-1];
      bmsb_d  = b[WIDTH-1];
    end else if (state_q == S_RUN) begin
      sa_d    = sa_q >> 1;
      sb_d    = sb_q >> 1;
      acc_d   = acc_next;
      carry_d = fa_c;
      cnt_d   = cnt_q + 1'b1;
      // Published results change only here, so they hold across later starts.
      if (last_bit) begin
        sum_d  = acc_next;
        cout_d = fa_c;
        ovf_d  = (amsb_q == bmsb_q) && (fa_s != amsb_q);
      end
    end
  end

  always_comb begin
    busy     = (state_q == S_RUN);
    done     = (state_q == S_DONE);
    sum      = sum_q;
    cout     = cout_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_serial_adder8.sv
// Self-checking bench for serial_adder8: transaction-level reference model, directed vectors, random traffic.
module tb_serial_adder8;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, cout, overflow;
  logic [W-1:0] sum;

  int checks   = 0;
  int failures = 0;
  int n_done   = 0;

  serial_adder8 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request yields {cout,sum} = a+b+cin exactly W edges later.
  int           cyc = 0;
  int           done_edge = 0;
  bit           pend = 1'b0;
  int           full_v, sgn_v;
  logic signed [W-1:0] as_v, bs_v;
  logic [W-1:0] p_sum = '0;
  logic         p_cout = 1'b0, p_ovf = 1'b0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_sum = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (pend && cyc == done_edge) begin
        m_sum  = p_sum;
        m_cout = p_cout;
        m_ovf  = p_ovf;
        m_done = 1'b1;
        pend   = 1'b0;
      end else if (!pend && start) begin
        full_v = int'(a) + int'(b) + (cin ? 1 : 0);
        p_sum  = full_v[W-1:0];
        p_cout = full_v[W];
        as_v   = a;
        bs_v   = b;
        sgn_v  = int'(as_v) + int'(bs_v) + (cin ? 1 : 0);
        p_ovf  = (sgn_v > (2**(W-1)) - 1) || (sgn_v < -(2**(W-1)));
        pend   = 1'b1;
        done_edge = cyc + W;
      end
      m_busy = pend;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("sum", sum, m_sum);
    chk("cout", cout, m_cout);
    chk("overflow", overflow, m_ovf);
    if (done) n_done++;
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                       input logic [W-1:0] es, input logic ec, input logic eo, input int noise_at);
    int  n_busy;
    bit  seen;
    int  dones_before;
    n_busy = 0;
    seen   = 1'b0;
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    dones_before = n_done;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
      start = (i + 1 == noise_at);
      if (start) begin a = 8'h01; b = 8'h01; end
    end
    start = 1'b0;
    chk("op_done_seen", seen, 1'b1);
    chk("op_busy_cycles", n_busy, W);
    chk("op_sum", sum, es);
    chk("op_cout", cout, ec);
    chk("op_overflow", overflow, eo);
    chk("model_sum", m_sum, es);
    chk("model_cout", m_cout, ec);
    @(posedge clk); #1;
    @(negedge clk);
    chk("op_done_single", done, 1'b0);
    chk("op_done_count", n_done - dones_before, 1);
  endtask

  initial begin
    int  n_wait;
    bit  seen;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, -1);
    do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, -1);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1);
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1);
    do_op(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, -1);
    do_op(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 2);

    // Start held high through DONE: the second request is taken on the done cycle.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk("b2b_first_done", seen, 1'b1);
    chk("b2b_first_sum", sum, 8'h30);
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'h00; b = 8'h00;
    seen = 1'b0;
    n_wait = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) chk("b2b_accepted", busy, 1'b1);
      if (done) begin seen = 1'b1; break; end
      n_wait++;
    end
    chk("b2b_second_done", seen, 1'b1);
    chk("b2b_latency", n_wait, W);
    chk("b2b_second_sum", sum, 8'h30);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a run.
    a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_sum", sum, 8'h00);
    chk("mid_rst_cout", cout, 1'b0);
    chk("mid_rst_overflow", overflow, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst_no_done", done, 1'b0);
      chk("post_rst_idle", busy, 1'b0);
    end

    // Random traffic, including starts that land while busy.
    n_wait = n_done;
    @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) begin
      start = (($urandom % 3) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("random_enough_dones", (n_done - n_wait) > 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder8.md
Name: serial_adder8

Overview:
- Bit-serial, multi-cycle 8-bit adder with carry-in.
- Inverse arithmetic counterpart to the team's combinational subtractor chain.
- Trades area for latency: one full-adder cell processes one bit per clock, LSB first.
- Sits beside the ALU as the low-area add path, driven by a start/done handshake from the sequencer.

Parameters:
WIDTH, 8, operand/result width in bits (counter sized to clog2(WIDTH)+1)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when ready (IDLE or DONE state)
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while bits are being processed (RUN state)
done  output  1  single-cycle pulse: result valid and updated
sum  output  WIDTH  result, held until next completion
cout  output  1  unsigned carry-out of bit WIDTH-1
overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset (async assert, any state): state=IDLE. busy, done, sum, cout, overflow, internal shift registers, carry and counter all 0. Release is synchronous to clk.
- States:
  - IDLE
  - RUN (busy=1)
  - DONE (done=1, lasts exactly one cycle)
- IDLE:
  - start=1 at a rising edge: latch a->sa, b->sb, cin->carry, a[WIDTH-1] and b[WIDTH-1] for overflow; cnt=0; go RUN.
  - start=0: stay.
- RUN, each edge:
  - fa_cell(sa[0], sb[0], carry) -> (s, c).
  - sa and sb shift right by 1.
  - Shift s into MSB of acc; acc shifts right.
  - carry=c; cnt++.
  - When cnt reaches WIDTH-1 on this edge (last bit):
    - sum <= final acc.
    - cout <= c.
    - overflow <= (aMSB==bMSB) && (final sum MSB != aMSB).
    - done <= 1; go DONE.
- Latency: start sampled at edge k -> busy high from k to k+WIDTH. sum, cout and overflow update and done=1 after edge k+WIDTH. For WIDTH=8, done is visible 8 cycles after the start edge.
- DONE: done falls at the next edge.
  - If start=1 on that edge: back-to-back accept, capture new operands, go RUN.
  - Otherwise go IDLE.
- start while RUN: ignored, no effect on operands or timing.
- Operand inputs a/b/cin may change freely after the accepting edge.
- sum/cout/overflow are not cleared on start; they hold the previous result until the next done.
- Arithmetic is modulo 2^WIDTH: {cout,sum} = a + b + cin exactly.
- Reset mid-RUN: operation aborted, outputs zeroed, no done pulse.

Decomposition:
- Shared package (mega8_alu_pkg): state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2; default WIDTH=8.
- One sub-module: fa_cell (combinational full adder: a, b, cin -> s, cout), instantiated once.
- FSM, shift registers and counter live in serial_adder8.

Test Plan:
- Reset then a=0x00, b=0x00, cin=0, start 1 cycle -> busy 8 cycles, done pulse, sum=0x00, cout=0, overflow=0.
- a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, overflow=0. Separately, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0.
- a=0x7F, b=0x01 -> sum=0x80, overflow=1, cout=0. Separately, a=0x80, b=0xFF -> sum=0x7F, cout=1, overflow=1.
- a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1. Also pulse start=1 with a=0x01, b=0x01 at cycle 3 of RUN -> ignored, result still 0x00, single done.
- Start held high through DONE with a=0x10, b=0x20 -> second op accepted on the done cycle, next done exactly 8 cycles later, sum=0x30.
- Assert rst_n=0 at cycle 4 of RUN -> busy/done/sum/cout/overflow = 0 immediately (async). After release, idle until the next start; no stray done.
